sd_modulator_2nd: RTL and testbench
===================================

# sd_modulator_2nd

Second-order, single-bit sigma-delta modulator that sits directly downstream of the interpolating filter in the DAC datapath. It consumes the interpolator's 16-bit signed output samples, qualified by the filter's `ce_out` strobe. Each qualified sample advances a two-integrator feedback loop, which emits one bitstream bit per sample for the analog reconstruction filter. The block also reports integrator saturation (overload) so firmware can back off the digital gain.

## Interface
Parameters:
- `DATA_W`, default 16: input sample width, signed two's complement.
- `ACC_W`, default 20: integrator width, signed; must be ≥ DATA_W+3.

Ports:
- `clk`, input, 1: the single clock.
- `reset`, input, 1: synchronous, active-high. Clears all state on the next rising edge of `clk`.
- `clk_enable`, input, 1: global enable. When 0, all state holds and `in_valid` is ignored.
- `in_valid`, input, 1: sample strobe, driven from the interpolator's `ce_out`.
- `input_data`, input, DATA_W: signed sample. Sampled only when `clk_enable & in_valid` is 1.
- `overload_clr`, input, 1: clears the sticky `overload` flag.
- `dac_out`, output, 1: bitstream output, registered.
- `out_valid`, output, 1: single-cycle pulse; asserted when `dac_out` has just updated.
- `overload`, output, 1: sticky flag set on any integrator saturation.
- `sat_count`, output, 16: number of saturating steps; saturates at 0xFFFF and does not wrap.

## Operation
- Step definition: a step occurs on any cycle where `reset` is 0, `clk_enable` is 1 and `in_valid` is 1. No other cycle modifies `int1`, `int2` or `dac_out`.
- State:
  - `int1` and `int2`: ACC_W-bit signed integrators.
  - `dac_out`.
  - `overload`.
  - `sat_count`.
- Quantizer: `y = 1` when `int2 >= 0`, otherwise `y = 0`. It uses the registered value of `int2`, before the update.
- Feedback: `fb = +2^(DATA_W-1)` when `y` is 1, `-2^(DATA_W-1)` when `y` is 0. For the defaults this is ±32768.
- Update on each step, with `x = sign-extend(input_data)` and both right-hand sides using the old register values:
  - `int1 <= sat(int1 + x - fb)`
  - `int2 <= sat(int2 + int1 - fb)`
- Arithmetic:
  - Sums are computed at ACC_W+2 bits.
  - `sat()` clamps the result to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
- Output: `dac_out <= y` on each step.
- Saturation reporting:
  - A step is "saturating" if either clamp engages.
  - On a saturating step, `overload` is set to 1 and `sat_count` increments, unless it is already 0xFFFF.
- Flag clearing:
  - `overload_clr` clears `overload` when no saturating step occurs in the same cycle.
  - If a saturating step and `overload_clr` occur in the same cycle, the set wins and `overload` stays 1.
  - `overload_clr` does not affect `sat_count`.
- `input_data` is ignored on non-step cycles. There is no input buffering and no backpressure: the upstream strobe rate is the modulator rate.

## Timing
- Reset values: `int1 = 0`, `int2 = 0`, `dac_out = 0`, `out_valid = 0`, `overload = 0`, `sat_count = 0`.
- `reset` has priority over `clk_enable`, `in_valid` and `overload_clr`.
- Reset asserted mid-stream clears all state at the next edge. The first step after reset produces `y = 1`, because `int2 = 0`.
- `out_valid` is registered. It is 1 in the cycle after a step edge, i.e. exactly one cycle per step, and 0 otherwise, including while `clk_enable` is 0.
- Latency:
  - A sample taken at step n first affects `int1` after step n and `int2` after step n+1.
  - Its first influence on `dac_out` is therefore the value emitted at step n+2.
- Back-to-back steps, meaning `in_valid` held at 1, are supported at one per cycle.
- `clk_enable` = 0 freezes everything except `overload_clr`, which still clears `overload`.

## Test plan
- DC zero:
  - Stimulus: after reset, `input_data = 0` with `in_valid = 1` continuously.
  - Required: `dac_out` sequence is 1,0,0,1 repeating; `overload` stays 0.
- DC +0.5 FS:
  - Stimulus: `input_data = 16384` for 4096 steps.
  - Required: number of ones is 3072 ±4; `overload` stays 0.
- Strobe gating:
  - Stimulus: `in_valid` pulsed every 4th cycle, with `clk_enable` dropped for 10 cycles mid-run.
  - Required: the `dac_out` sequence matches the continuous-strobe reference model step-for-step; `out_valid` pulses exactly once per step.
- Overload:
  - Stimulus: `input_data = 32767` for 200 steps.
  - Required: `overload` becomes 1 and `sat_count` is > 0 and nonzero-monotonic. Then `overload_clr` with `input_data = 0`: `overload` goes to 0 and stays 0 once the integrators recover, while `sat_count` holds.
- Clear/set collision:
  - Stimulus: `overload_clr` asserted in the same cycle as a saturating step.
  - Required: `overload` remains 1.
- Reset mid-operation:
  - Stimulus: assert `reset` for 1 cycle during the full-scale run.
  - Required: all outputs read reset values the next cycle; the next step yields `dac_out = 1`.

Source files
------------

// File: rtl/sd_modulator_2nd_if.sv
// Sample/bitstream bus between the interpolator, the sigma-delta modulator and status readers.
// The master drives the strobed samples and the overload clear; the slave returns the bitstream and status.
interface sd_modulator_2nd_if #(
    parameter int DATA_W = 16
);
    logic                     clk_enable;
    logic                     in_valid;
    logic signed [DATA_W-1:0] input_data;
    logic                     overload_clr;
    logic                     dac_out;
    logic                     out_valid;
    logic                     overload;
    logic [15:0]              sat_count;

    modport master (
        output clk_enable, in_valid, input_data, overload_clr,
        input  dac_out, out_valid, overload, sat_count
    );

    modport slave (
        input  clk_enable, in_valid, input_data, overload_clr,
        output dac_out, out_valid, overload, sat_count
    );
endinterface

// File: rtl/sd_modulator_2nd.sv
// Second-order single-bit sigma-delta modulator with saturating integrators.
// Also reports saturation through a sticky overload flag and a saturating event counter.
module sd_modulator_2nd #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 20
) (
    input  logic              clk,
    input  logic              reset,
    sd_modulator_2nd_if.slave bus
);
    localparam int SUM_W = ACC_W + 2;

    typedef logic signed [ACC_W-1:0] acc_t;
    typedef logic signed [SUM_W-1:0] sum_t;

    localparam sum_t SAT_HI = {3'b000, {(ACC_W-1){1'b1}}};
    localparam sum_t SAT_LO = {3'b111, {(ACC_W-1){1'b0}}};
    localparam sum_t FB_POS = {{(SUM_W-DATA_W){1'b0}}, 1'b1, {(DATA_W-1){1'b0}}};
    localparam sum_t FB_NEG = {{(SUM_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    acc_t        int1_q, int1_d;
    acc_t        int2_q, int2_d;
    logic        dac_q;
    logic        out_valid_q;
    logic        overload_q;
    logic [15:0] sat_count_q;

    logic step, y, sat1, sat2, sat_step;
    sum_t x_ext, fb, sum1, sum2;

    always_comb begin
        step  = bus.clk_enable & bus.in_valid;
        // Quantizer looks at the pre-update int2, so feedback and output agree in the same step.
        y     = ~int2_q[ACC_W-1];
        fb    = y ? FB_POS : FB_NEG;
        x_ext = sum_t'(bus.input_data);
        sum1  = sum_t'(int1_q) + x_ext - fb;
        sum2  = sum_t'(int2_q) + sum_t'(int1_q) - fb;

        sat1   = 1'b0;
        int1_d = sum1[ACC_W-1:0];
        if (sum1 > SAT_HI) begin
            sat1   = 1'b1;
            int1_d = SAT_HI[ACC_W-1:0];
        end else if (sum1 < SAT_LO) begin
            sat1   = 1'b1;
            int1_d = SAT_LO[ACC_W-1:0];
        end

        sat2   = 1'b0;
        int2_d = sum2[ACC_W-1:0];
        if (sum2 > SAT_HI) begin
            sat2   = 1'b1;
            int2_d = SAT_HI[ACC_W-1:0];
        end else if (sum2 < SAT_LO) begin
            sat2   = 1'b1;
            int2_d = SAT_LO[ACC_W-1:0];
        end

        sat_step = step & (sat1 | sat2);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            int1_q      <= '0;
            int2_q      <= '0;
            dac_q       <= 1'b0;
            out_valid_q <= 1'b0;
            overload_q  <= 1'b0;
            sat_count_q <= '0;
        end else begin
            out_valid_q <= step;
            if (step) begin
                int1_q <= int1_d;
                int2_q <= int2_d;
                dac_q  <= y;
            end
            // A saturating step outranks a simultaneous clear.
            if (sat_step) begin
                overload_q <= 1'b1;
                if (sat_count_q != 16'hFFFF)
                    sat_count_q <= sat_count_q + 16'd1;
            end else if (bus.overload_clr) begin
                overload_q <= 1'b0;
            end
        end
    end

    assign bus.dac_out   = dac_q;
    assign bus.out_valid = out_valid_q;
    assign bus.overload  = overload_q;
    assign bus.sat_count = sat_count_q;
endmodule

// File: tb/tb_sd_modulator_2nd.sv
// Directed bench for sd_modulator_2nd: hand-computed vector table plus model-checked multi-cycle sequences.
module tb_sd_modulator_2nd;
    localparam int DW = 16;
    localparam int AW = 20;
    localparam int AMAX = (1 << (AW-1)) - 1;
    localparam int AMIN = -(1 << (AW-1));
    localparam int FS = 1 << (DW-1);

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sd_modulator_2nd_if #(.DATA_W(DW)) bus();
    sd_modulator_2nd #(.DATA_W(DW), .ACC_W(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

    int errors = 0;
    int checks = 0;

    // Reference model state
    int m1, m2, m_cnt;
    bit m_dac, m_vld, m_ov, m_sat;

    typedef struct {
        bit en; bit v; int x; bit clr;
        bit dac; bit vld; bit ov;
    } vec_t;
    vec_t tv[15];

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_range(input string nm, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
        end
    endtask

    task automatic chk_model(input string nm);
        check({nm, ".dac"}, int'(bus.dac_out), int'(m_dac));
        check({nm, ".vld"}, int'(bus.out_valid), int'(m_vld));
        check({nm, ".ov"}, int'(bus.overload), int'(m_ov));
        check({nm, ".cnt"}, int'(bus.sat_count), m_cnt);
    endtask

    // Drive one cycle, then advance the model with the same inputs.
    task automatic tick(input bit r, input bit en, input bit v, input int x, input bit clr);
        int fb, n1, n2;
        reset            = r;
        bus.clk_enable   = en;
        bus.in_valid     = v;
        bus.input_data   = DW'(x);
        bus.overload_clr = clr;
        @(posedge clk);
        #1;
        if (r) begin
            m1 = 0; m2 = 0; m_dac = 0; m_vld = 0; m_ov = 0; m_cnt = 0;
        end else begin
            m_vld = en && v;
            m_sat = 0;
            if (en && v) begin
                m_dac = (m2 >= 0);
                fb = m_dac ? FS : -FS;
                n1 = m1 + x - fb;
                n2 = m2 + m1 - fb;
                if (n1 > AMAX) begin n1 = AMAX; m_sat = 1; end
                if (n1 < AMIN) begin n1 = AMIN; m_sat = 1; end
                if (n2 > AMAX) begin n2 = AMAX; m_sat = 1; end
                if (n2 < AMIN) begin n2 = AMIN; m_sat = 1; end
                m1 = n1;
                m2 = n2;
                if (m_sat) begin
                    m_ov = 1;
                    if (m_cnt < 65535) m_cnt++;
                end
            end
            if (clr && !m_sat) m_ov = 0;
        end
    endtask

    task automatic check_reset_vals(input string nm);
        check({nm, ".dac"}, int'(bus.dac_out), 0);
        check({nm, ".vld"}, int'(bus.out_valid), 0);
        check({nm, ".ov"}, int'(bus.overload), 0);
        check({nm, ".cnt"}, int'(bus.sat_count), 0);
    endtask

    initial begin
        int ones, steps, pulses, prev_cnt, held;

        // {en, v, x, clr, dac, vld, ov}
        tv[0]  = '{1, 1, 0,     0, 1, 1, 0};
        tv[1]  = '{1, 1, 0,     0, 0, 1, 0};
        tv[2]  = '{1, 0, 12345, 0, 0, 0, 0};
        tv[3]  = '{0, 1, 9999,  0, 0, 0, 0};
        tv[4]  = '{1, 1, 0,     0, 0, 1, 0};
        tv[5]  = '{1, 1, 0,     0, 1, 1, 0};
        tv[6]  = '{1, 1, 0,     0, 1, 1, 0};
        tv[7]  = '{1, 1, 0,     0, 0, 1, 0};
        tv[8]  = '{1, 1, 16384, 0, 0, 1, 0};
        tv[9]  = '{1, 1, 16384, 0, 1, 1, 0};
        tv[10] = '{1, 1, 16384, 0, 1, 1, 0};
        tv[11] = '{1, 1, 16384, 0, 1, 1, 0};
        tv[12] = '{1, 1, 16384, 0, 1, 1, 0};
        tv[13] = '{1, 1, 16384, 0, 0, 1, 0};
        tv[14] = '{1, 1, 16384, 1, 0, 1, 0};

        // Reset wins over an active strobe and clear.
        tick(1, 1, 1, 32767, 1);
        tick(1, 1, 1, 32767, 1);
        check_reset_vals("reset");

        for (int i = 0; i < 15; i++) begin
            tick(0, tv[i].en, tv[i].v, tv[i].x, tv[i].clr);
            check($sformatf("tv%0d.dac", i), int'(bus.dac_out), int'(tv[i].dac));
            check($sformatf("tv%0d.vld", i), int'(bus.out_valid), int'(tv[i].vld));
            check($sformatf("tv%0d.ov", i), int'(bus.overload), int'(tv[i].ov));
            check($sformatf("tv%0d.cnt", i), int'(bus.sat_count), 0);
        end

        // DC zero: 1,0,0,1 repeating
        tick(1, 0, 0, 0, 0);
        for (int k = 0; k < 40; k++) begin
            tick(0, 1, 1, 0, 0);
            check($sformatf("dc0.dac%0d", k), int'(bus.dac_out), (k % 4 == 0 || k % 4 == 3) ? 1 : 0);
            check("dc0.ov", int'(bus.overload), 0);
        end

        // DC +0.5 FS: density of ones is 3/4
        tick(1, 0, 0, 0, 0);
        ones = 0;
        for (int k = 0; k < 4096; k++) begin
            tick(0, 1, 1, 16384, 0);
            ones += int'(bus.dac_out);
        end
        check_range("dchalf.ones", ones, 3068, 3076);
        check("dchalf.ov", int'(bus.overload), 0);

        // Strobe gating with an enable hole
        tick(1, 0, 0, 0, 0);
        steps = 0;
        pulses = 0;
        for (int c = 0; c < 160; c++) begin
            bit en, v;
            en = !(c >= 60 && c < 70);
            v  = (c % 4 == 0) || (c >= 60 && c < 70);
            if (en && v) steps++;
            tick(0, en, v, ((c * 1237) % 20000) - 10000, 0);
            pulses += int'(bus.out_valid);
            check($sformatf("gate.vld%0d", c), int'(bus.out_valid), int'(m_vld));
            if (m_vld) check($sformatf("gate.dac%0d", c), int'(bus.dac_out), int'(m_dac));
        end
        check("gate.pulses", pulses, steps);

        // Full-scale overload, with a clear colliding with a saturating step
        tick(1, 0, 0, 0, 0);
        prev_cnt = 0;
        for (int k = 0; k < 200; k++) begin
            tick(0, 1, 1, 32767, k == 150);
            chk_model($sformatf("ovl%0d", k));
            check_range("ovl.mono", int'(bus.sat_count), prev_cnt, prev_cnt + 1);
            prev_cnt = int'(bus.sat_count);
            if (k == 150) check("collide.ov", int'(bus.overload), 1);
        end
        check("ovl.ov_end", int'(bus.overload), 1);
        check_range("ovl.cnt_end", int'(bus.sat_count), 1, 65535);

        held = int'(bus.sat_count);
        tick(0, 1, 0, 0, 1);
        check("clr.ov", int'(bus.overload), 0);
        check("clr.cnt", int'(bus.sat_count), held);
        for (int k = 0; k < 300; k++) begin
            tick(0, 1, 1, 0, 0);
            chk_model($sformatf("rec%0d", k));
        end
        tick(0, 0, 0, 0, 1);
        chk_model("clr_dis");
        for (int k = 0; k < 50; k++) begin
            tick(0, 1, 1, 0, 0);
            chk_model($sformatf("post%0d", k));
        end

        // Reset in the middle of a full-scale run
        for (int k = 0; k < 20; k++) tick(0, 1, 1, 32767, 0);
        tick(1, 1, 1, 32767, 0);
        check_reset_vals("midrst");
        tick(0, 1, 1, 32767, 0);
        check("midrst.first_dac", int'(bus.dac_out), 1);
        check("midrst.first_vld", int'(bus.out_valid), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
